// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: exception codes,
// vector offsets and the store-handshake state encoding.
package pipe_ctrl_pkg;

  localparam logic [31:0] EXC_NONE = 32'h00;
  localparam logic [31:0] EXC_INT  = 32'h01;
  localparam logic [31:0] EXC_SYS  = 32'h08;
  localparam logic [31:0] EXC_RI   = 32'h0a;
  localparam logic [31:0] EXC_OV   = 32'h0c;
  localparam logic [31:0] EXC_TR   = 32'h0d;
  localparam logic [31:0] EXC_ERET = 32'h0e;
  localparam logic [31:0] EXC_TLB  = 32'h0f;

  localparam logic [31:0] VEC_INT_OFS = 32'h180;
  localparam logic [31:0] VEC_GEN_OFS = 32'h42c;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STROBE = 2'd2
  } store_state_e;

endpackage

// File: rtl/exc_vector_sel.sv
// Exception code to redirect PC mux; yields 0 when no exception is pending.
import pipe_ctrl_pkg::*;

module exc_vector_sel #(
  parameter int            AW    = 32,
  parameter logic [AW-1:0] EBASE = AW'(32'h80001000)
) (
  input  logic [31:0]   excepttype,
  input  logic [AW-1:0] epc,
  output logic [AW-1:0] new_pc
);

  // Sums are AW bits wide and wrap naturally.
  always_comb begin
    case (excepttype)
      EXC_NONE: new_pc = '0;
      EXC_INT:  new_pc = EBASE + AW'(VEC_INT_OFS);
      EXC_ERET: new_pc = epc;
      default:  new_pc = EBASE + AW'(VEC_GEN_OFS);
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Parametrised pipeline stall/flush controller with store-handshake FSM.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
import pipe_ctrl_pkg::*;

module pipe_ctrl_gen #(
  parameter int            STAGES     = 6,
  parameter int            MEM_STAGE  = 4,
  parameter int            STORE_WAIT = 1,
  parameter int            AW         = 32,
  parameter logic [AW-1:0] EBASE      = AW'(32'h80001000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic              mem_we_i,
  input  logic [31:0]       excepttype_i,
  input  logic [AW-1:0]     cp0_epc_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic [AW-1:0]     new_pc_o,
  output logic              mem_we_o,
  output logic              store_busy_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  input  logic              perf_clr_i,
  output logic [31:0]       stall_cycles_o,
  output logic [31:0]       flush_count_o
`endif
);

  localparam logic [STAGES-1:0] ONES     = '1;
  localparam logic [STAGES-1:0] MASK_MEM = ONES >> (STAGES - 1 - MEM_STAGE);
  localparam logic [STAGES-1:0] MASK_STB = ONES >> (STAGES - MEM_STAGE);

  store_state_e      state;
  logic [3:0]        cnt;
  logic              exc;
  logic              hold;
  logic [STAGES-1:0] req_mask;
  logic [STAGES-1:0] store_mask;
  logic [AW-1:0]     vec_pc;

  assign exc  = |excepttype_i;
  assign hold = |stallreq_i;

  exc_vector_sel #(.AW(AW), .EBASE(EBASE)) u_vec (
    .excepttype (excepttype_i),
    .epc        (cp0_epc_i),
    .new_pc     (vec_pc)
  );

  always_comb begin
    req_mask = '0;
    for (int k = 0; k < STAGES; k++)
      if (stallreq_i[k]) req_mask |= ONES >> (STAGES - 1 - k);
  end

  // The store sequence starts combinationally in the IDLE cycle it is seen.
  always_comb begin
    case (state)
      ST_IDLE:   store_mask = (mem_we_i && !hold) ? MASK_MEM : '0;
      ST_WAIT:   store_mask = MASK_MEM;
      ST_STROBE: store_mask = MASK_STB;
      default:   store_mask = '0;
    endcase
  end

  always_comb begin
    stall_o      = '0;
    flush_o      = 1'b0;
    new_pc_o     = '0;
    mem_we_o     = 1'b0;
    store_busy_o = 1'b0;
    if (!rst) begin
      store_busy_o = (state != ST_IDLE);
      if (exc) begin
        flush_o  = 1'b1;
        new_pc_o = vec_pc;
      end else begin
        stall_o  = req_mask | store_mask;
        mem_we_o = (state == ST_STROBE) && mem_we_i && !hold;
      end
    end
  end

  // The IDLE entry cycle is the first wait cycle, so WAIT lasts STORE_WAIT-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else if (exc) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else if (!hold) begin
      case (state)
        ST_IDLE: begin
          if (mem_we_i) begin
            state <= (STORE_WAIT == 1) ? ST_STROBE : ST_WAIT;
            cnt   <= 4'(STORE_WAIT - 1);
          end
        end
        ST_WAIT: begin
          if (!mem_we_i) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= ST_STROBE;
          end
        end
        ST_STROBE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || perf_clr_i) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if ((|stall_o) && (stall_cycles_o != 32'hFFFF_FFFF))
        stall_cycles_o <= stall_cycles_o + 32'd1;
      if (flush_o && (flush_count_o != 32'hFFFF_FFFF))
        flush_count_o <= flush_count_o + 32'd1;
    end
  end
`endif

endmodule
